// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: valid/ready elastic pipeline buffer with flush and occupancy report
module pipe_stage_elastic #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             Flush,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] InData,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] OutData,
    output logic [CW-1:0]    Count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wp;
    logic [PW-1:0]    r_rp;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign InReady  = r_count < CW'(DEPTH);
    assign OutValid = r_count != '0;
    assign OutData  = OutValid ? r_mem[r_rp] : '0;
    assign Count    = r_count;
    assign w_push   = InValid & InReady;
    assign w_pop    = OutValid & OutReady;

    // payload storage; contents are meaningless until the pointers say otherwise, so no reset
    always_ff @(posedge Clock) begin
        if (w_push && !Flush)
            r_mem[r_wp] <= InData;
    end

    // pointers and occupancy: reset beats flush, flush beats push/pop
    always_ff @(posedge Clock) begin
        if (!nReset || Flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wp <= f_inc(r_wp);
            if (w_pop)
                r_rp <= f_inc(r_rp);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic: directed checks of the elastic stage at DEPTH=2 and DEPTH=3
module tb_pipe_stage_elastic;
    logic        Clock = 1'b0;
    logic        nReset = 1'b0;
    logic        a_flush = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
    logic        a_in_ready, a_out_valid;
    logic [31:0] a_in_data = '0, a_out_data;
    logic [1:0]  a_count;
    logic        b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
    logic        b_in_ready, b_out_valid;
    logic [7:0]  b_in_data = '0, b_out_data;
    logic [1:0]  b_count;
    int          checks = 0;
    int          failures = 0;

    pipe_stage_elastic #(.WIDTH(32), .DEPTH(2)) u_d2 (
        .Clock(Clock), .nReset(nReset), .Flush(a_flush), .InValid(a_in_valid),
        .InReady(a_in_ready), .InData(a_in_data), .OutValid(a_out_valid),
        .OutReady(a_out_ready), .OutData(a_out_data), .Count(a_count)
    );

    pipe_stage_elastic #(.WIDTH(8), .DEPTH(3)) u_d3 (
        .Clock(Clock), .nReset(nReset), .Flush(b_flush), .InValid(b_in_valid),
        .InReady(b_in_ready), .InData(b_in_data), .OutValid(b_out_valid),
        .OutReady(b_out_ready), .OutData(b_out_data), .Count(b_count)
    );

    always #5 Clock = ~Clock;

    task automatic step;
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic test_reset;
        nReset = 1'b0; a_in_valid = 1'b1; a_in_data = 32'h55;
        step; step;
        checks++; if (a_count !== 2'd0) begin failures++; $display("FAIL reset_count actual=%0d expected=0", a_count); end
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid actual=%b expected=0", a_out_valid); end
        checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready actual=%b expected=1", a_in_ready); end
        checks++; if (a_out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data actual=%h expected=0", a_out_data); end
        a_in_valid = 1'b0; nReset = 1'b1;
        step;
    endtask

    task automatic test_backpressure;
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 32'hA1;
        step;
        a_in_data = 32'hB2;
        step;
        checks++; if (a_count !== 2'd2) begin failures++; $display("FAIL bp_full_count actual=%0d expected=2", a_count); end
        checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_in_ready actual=%b expected=0", a_in_ready); end
        checks++; if (a_out_data !== 32'hA1) begin failures++; $display("FAIL bp_head actual=%h expected=a1", a_out_data); end
        a_in_data = 32'hC3;
        step;
        checks++; if (a_count !== 2'd2) begin failures++; $display("FAIL bp_c3_refused_count actual=%0d expected=2", a_count); end
        a_out_ready = 1'b1;
        step;
        checks++; if (a_count !== 2'd1) begin failures++; $display("FAIL bp_pop_no_push_count actual=%0d expected=1", a_count); end
        checks++; if (a_out_data !== 32'hB2) begin failures++; $display("FAIL bp_second_word actual=%h expected=b2", a_out_data); end
        checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL bp_in_ready_after_pop actual=%b expected=1", a_in_ready); end
        a_in_valid = 1'b0;
        step;
        checks++; if (a_count !== 2'd0) begin failures++; $display("FAIL bp_drained_count actual=%0d expected=0", a_count); end
        checks++; if (a_out_data !== 32'h0) begin failures++; $display("FAIL bp_empty_data actual=%h expected=0", a_out_data); end
        step;
        checks++; if (a_count !== 2'd0 || a_out_valid !== 1'b0) begin failures++; $display("FAIL bp_no_underflow count=%0d valid=%b expected 0/0", a_count, a_out_valid); end
        a_out_ready = 1'b0;
    endtask

    task automatic test_stream;
        a_in_valid = 1'b1; a_out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a_in_data = 32'(i);
            step;
            checks++; if (a_count !== 2'd1) begin failures++; $display("FAIL stream_count[%0d] actual=%0d expected=1", i, a_count); end
            checks++; if (a_out_data !== 32'(i) || a_out_valid !== 1'b1) begin failures++; $display("FAIL stream_data[%0d] actual=%h valid=%b expected=%h", i, a_out_data, a_out_valid, i); end
        end
        a_in_valid = 1'b0;
        step;
        checks++; if (a_count !== 2'd0) begin failures++; $display("FAIL stream_drain actual=%0d expected=0", a_count); end
        a_out_ready = 1'b0;
    endtask

    task automatic test_flush;
        a_in_valid = 1'b1; a_in_data = 32'h11;
        step;
        a_in_data = 32'h22;
        step;
        a_flush = 1'b1; a_in_data = 32'hDD; a_out_ready = 1'b1;
        step;
        checks++; if (a_count !== 2'd0) begin failures++; $display("FAIL flush_full_count actual=%0d expected=0", a_count); end
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL flush_full_valid actual=%b expected=0", a_out_valid); end
        a_flush = 1'b0; a_out_ready = 1'b0; a_in_data = 32'h44;
        step;
        a_flush = 1'b1; a_in_data = 32'hDD; a_out_ready = 1'b1;
        step;
        checks++; if (a_count !== 2'd0) begin failures++; $display("FAIL flush_push_dropped actual=%0d expected=0", a_count); end
        a_flush = 1'b0; a_out_ready = 1'b0; a_in_data = 32'h33;
        step;
        a_in_valid = 1'b0;
        checks++; if (a_out_data !== 32'h33 || a_count !== 2'd1) begin failures++; $display("FAIL flush_after_push actual=%h count=%0d expected=33 count=1", a_out_data, a_count); end
        a_out_ready = 1'b1;
        step;
        a_out_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        a_in_valid = 1'b1; a_in_data = 32'h77;
        step; step;
        nReset = 1'b0;
        step;
        checks++; if (a_count !== 2'd0) begin failures++; $display("FAIL rstmid_count actual=%0d expected=0", a_count); end
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid actual=%b expected=0", a_out_valid); end
        checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready actual=%b expected=1", a_in_ready); end
        nReset = 1'b1; a_in_valid = 1'b0;
        step;
    endtask

    task automatic test_wrap_d3;
        logic [15:0] pat;
        int          sent, recv, cnt;
        logic        push, pop;
        pat = 16'b1101_1100_0110_1000;
        sent = 0; recv = 0; cnt = 0;
        for (int c = 0; c < 100 && recv < 10; c++) begin
            b_in_valid  = sent < 10;
            b_in_data   = 8'(8'h30 + sent);
            b_out_ready = pat[c % 16];
            #1;
            push = b_in_valid & b_in_ready;
            pop  = b_out_valid & b_out_ready;
            if (pop) begin
                checks++;
                if (b_out_data !== 8'(8'h30 + recv)) begin
                    failures++;
                    $display("FAIL wrap_data[%0d] actual=%h expected=%h", recv, b_out_data, 8'(8'h30 + recv));
                end
                recv++;
            end
            if (push) sent++;
            cnt = cnt + int'(push) - int'(pop);
            step;
            checks++;
            if (b_count !== 2'(cnt)) begin failures++; $display("FAIL wrap_count[cycle %0d] actual=%0d expected=%0d", c, b_count, cnt); end
        end
        b_in_valid = 1'b0; b_out_ready = 1'b0;
        checks++; if (recv != 10) begin failures++; $display("FAIL wrap_received actual=%0d expected=10", recv); end
    endtask

    initial begin
        test_reset;
        test_backpressure;
        test_stream;
        test_flush;
        test_reset_mid;
        test_wrap_d3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
